mul_sequential: RTL

Iterative radix-2 shift-add multiplier. Takes two WIDTH-bit operands, signed or unsigned, and produces a 2·WIDTH-bit product after WIDTH iteration cycles. It is the multiplication counterpart to the non-restoring divider and uses the same start/busy/ready handshake, so the ID/EX stall logic drives both the same way. In the CPU it sits beside the divider and feeds MULT/MULTU results into HI/LO: HI = p[2W-1:W], LO = p[W-1:0].

---
 rtl/mul_sequential.sv | 82 ++++++++
 1 files changed

// File: rtl/mul_sequential.sv
//==============================================================================
// mul_sequential : iterative radix-2 shift-add multiplier, signed or unsigned,
//                  with start/busy/ready handshake.
// Revision 1.0
//==============================================================================
`default_nettype none

module mul_sequential #(
    parameter int WIDTH = 32,
    localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sign,
    input  logic               start,
    output logic [2*WIDTH-1:0] p,
    output logic               busy,
    output logic               ready,
    output logic [CW-1:0]      count
);

    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               neg_q;
    logic               busy_q;
    logic               busy2_q;
    logic [CW-1:0]      count_q;

    logic [WIDTH-1:0]   mcand_d;
    logic [WIDTH-1:0]   mplier_d;
    logic [WIDTH:0]     sum_d;
    logic [2*WIDTH-1:0] prod_d;

    // Magnitudes are unsigned, so the most negative operand maps cleanly onto 2^(W-1).
    assign mcand_d  = (sign & a[WIDTH-1]) ? ('0 - a) : a;
    assign mplier_d = (sign & b[WIDTH-1]) ? ('0 - b) : b;
    assign sum_d    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_d   = {hi_q, lo_q};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            busy2_q <= 1'b0;
            count_q <= '0;
        end else begin
            busy2_q <= busy_q;
            if (!busy_q) begin
                if (start) begin
                    mcand_q <= mcand_d;
                    lo_q    <= mplier_d;
                    hi_q    <= '0;
                    neg_q   <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                    count_q <= '0;
                    busy_q  <= 1'b1;
                end
            end else begin
                {hi_q, lo_q} <= {sum_d, lo_q[WIDTH-1:1]};
                if (count_q == CW'(WIDTH - 1)) begin
                    count_q <= '0;
                    busy_q  <= 1'b0;
                end else begin
                    count_q <= count_q + CW'(1);
                end
            end
        end
    end

    assign p     = neg_q ? ('0 - prod_d) : prod_d;
    assign busy  = busy_q;
    assign ready = ~busy_q & busy2_q;
    assign count = count_q;

endmodule

`default_nettype wire
